// File: rtl/rc522_reg_access.sv
// Register read/write sequencer for the RC522 over an 8-bit spi_master:
// sends the address byte, then a data or dummy byte, and returns the read byte.
//
// state      | meaning
// IDLE       | ready for a request
// ADDR_START | one-cycle start pulse for the address byte
// ADDR_WAIT  | waiting for the master to report busy
// ADDR_XFER  | address byte shifting; the received byte is discarded
// DATA_START | one-cycle start pulse for the data/dummy byte
// DATA_WAIT  | waiting for the master to report busy
// DATA_XFER  | data byte shifting; the received byte is captured on exit
// DONE       | one-cycle response
module rc522_reg_access #(
    parameter logic [27:0] XFER_TIMEOUT = 28'd50_000_000,
    parameter logic [7:0]  DUMMY_BYTE   = 8'h00
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [5:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       spi_start_n,
    output logic [7:0] spi_data_in,
    input  logic       spi_busy,
    input  logic [7:0] spi_data_out
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_START,
        ADDR_WAIT,
        ADDR_XFER,
        DATA_START,
        DATA_WAIT,
        DATA_XFER,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rw_q;
    logic [5:0]  addr_q;
    logic [7:0]  wdata_q;
    logic [27:0] cnt;
    logic        timeout;

    assign timeout     = (cnt >= XFER_TIMEOUT);
    assign req_ready   = (state == IDLE);
    assign rsp_valid   = (state == DONE);
    assign spi_start_n = !((state == ADDR_START) || (state == DATA_START));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (req_valid) state_nxt = ADDR_START;
            ADDR_START: state_nxt = ADDR_WAIT;
            ADDR_WAIT: begin
                if (timeout)       state_nxt = DONE;
                else if (spi_busy) state_nxt = ADDR_XFER;
            end
            ADDR_XFER: begin
                if (timeout)        state_nxt = DONE;
                else if (!spi_busy) state_nxt = DATA_START;
            end
            DATA_START: state_nxt = DATA_WAIT;
            DATA_WAIT: begin
                if (timeout)       state_nxt = DONE;
                else if (spi_busy) state_nxt = DATA_XFER;
            end
            DATA_XFER: begin
                if (timeout)        state_nxt = DONE;
                else if (!spi_busy) state_nxt = DONE;
            end
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rw_q        <= 1'b0;
            addr_q      <= 6'h00;
            wdata_q     <= 8'h00;
            cnt         <= 28'd0;
            rsp_data    <= 8'h00;
            rsp_err     <= 1'b0;
            spi_data_in <= 8'h00;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rw_q        <= req_rw;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        spi_data_in <= {req_rw, req_addr, 1'b0};
                    end
                end
                ADDR_START, DATA_START: cnt <= 28'd0;
                ADDR_WAIT, DATA_WAIT: begin
                    cnt <= cnt + 28'd1;
                    if (timeout) begin
                        rsp_err  <= 1'b1;
                        rsp_data <= 8'h00;
                    end
                end
                ADDR_XFER: begin
                    cnt <= cnt + 28'd1;
                    if (timeout) begin
                        rsp_err  <= 1'b1;
                        rsp_data <= 8'h00;
                    end else if (!spi_busy) begin
                        spi_data_in <= rw_q ? DUMMY_BYTE : wdata_q;
                    end
                end
                DATA_XFER: begin
                    cnt <= cnt + 28'd1;
                    if (timeout) begin
                        rsp_err  <= 1'b1;
                        rsp_data <= 8'h00;
                    end else if (!spi_busy) begin
                        rsp_err  <= 1'b0;
                        rsp_data <= rw_q ? spi_data_out : 8'h00;
                    end
                end
                default: ;
            endcase
        end
    end

    // addr_q is kept for observability of the latched request.
    logic unused_addr;
    assign unused_addr = ^addr_q;

endmodule

// File: tb/tb_rc522_reg_access.sv
// Scoreboard bench for rc522_reg_access: a behavioural SPI slave logs bytes,
// a monitor checks responses against expectations pushed by the stimulus.
module tb_rc522_reg_access;

    localparam logic [7:0] DUMMY = 8'h00;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rw = 1'b0;
    logic [5:0] req_addr = 6'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       spi_start_n;
    logic [7:0] spi_data_in;
    logic       spi_busy;
    logic [7:0] spi_data_out;

    logic       slave_busy = 1'b0;
    logic       stray_busy = 1'b0;
    logic       slave_en = 1'b1;
    logic [7:0] slave_dout = 8'h00;

    assign spi_busy     = slave_busy | stray_busy;
    assign spi_data_out = slave_dout;

    rc522_reg_access #(.XFER_TIMEOUT(28'd100), .DUMMY_BYTE(DUMMY)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .spi_start_n(spi_start_n), .spi_data_in(spi_data_in),
        .spi_busy(spi_busy), .spi_data_out(spi_data_out)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] data;
        logic       err;
        logic       lat;
    } rsp_t;

    logic [7:0] exp_byte[$];
    logic [7:0] slave_ret[$];
    rsp_t       exp_rsp[$];

    int start_pulses = 0;
    int last_fall_cyc = 0;
    int last_rsp_cyc = 0;
    int rsp_count = 0;
    int t_start = 0;
    logic [7:0] last_rsp_data = 8'h00;

    // SPI slave: busy rises 1-3 cycles after the start pulse and lasts 1-6 cycles.
    logic [7:0] sl_b;
    logic [7:0] sl_ret;
    initial forever begin
        @(negedge CLOCK_50);
        if (!spi_start_n && slave_en) begin
            sl_b = spi_data_in;
            if (exp_byte.size() == 0) check("byte_expected", 0, 1);
            else check("spi_byte", {24'h0, sl_b}, {24'h0, exp_byte.pop_front()});
            sl_ret = (slave_ret.size() != 0) ? slave_ret.pop_front() : 8'hEE;
            repeat ($urandom_range(1, 3)) @(posedge CLOCK_50);
            #1 slave_busy = 1'b1;
            slave_dout = sl_ret;
            repeat ($urandom_range(1, 6)) @(posedge CLOCK_50);
            #1;
            if (reset) check("data_in_stable", {24'h0, spi_data_in}, {24'h0, sl_b});
            slave_busy = 1'b0;
            last_fall_cyc = cyc;
        end
    end

    // Response monitor.
    rsp_t e;
    initial forever begin
        @(negedge CLOCK_50);
        if (!spi_start_n) start_pulses++;
        if (rsp_valid) begin
            if (exp_rsp.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                e = exp_rsp.pop_front();
                check("rsp_data", {24'h0, rsp_data}, {24'h0, e.data});
                check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                if (e.lat) check("rsp_latency", cyc, last_fall_cyc + 1);
                last_rsp_data = e.data;
            end
            last_rsp_cyc = cyc;
            rsp_count++;
        end
    end

    task automatic push_expect(input logic rw, input logic [5:0] addr, input logic [7:0] wd,
                               input logic [7:0] rd, input bit tmo);
        int ab;
        rsp_t r;
        ab = (rw ? 128 : 0) + int'(addr) * 2;
        if (!tmo) begin
            exp_byte.push_back(ab[7:0]);
            exp_byte.push_back(rw ? DUMMY : wd);
            slave_ret.push_back(8'($urandom));
            slave_ret.push_back(rd);
        end
        r.data = (rw && !tmo) ? rd : 8'h00;
        r.err  = tmo;
        r.lat  = !tmo;
        exp_rsp.push_back(r);
    endtask

    task automatic wait_ready();
        int w = 0;
        @(negedge CLOCK_50);
        while (!req_ready && w < 2000) begin
            @(negedge CLOCK_50);
            w++;
        end
        if (!req_ready) check("ready_wait_expired", 0, 1);
    endtask

    task automatic issue(input logic rw, input logic [5:0] addr, input logic [7:0] wd,
                         input logic [7:0] rd, input bit tmo);
        wait_ready();
        push_expect(rw, addr, wd, rd, tmo);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge CLOCK_50);
        #1 req_valid = 1'b0;
        @(negedge CLOCK_50);
        check("start_latency", {31'h0, spi_start_n}, 0);
        check("ready_low_after_accept", {31'h0, req_ready}, 0);
        t_start = cyc;
    endtask

    task automatic wait_idle();
        int w = 0;
        while ((exp_rsp.size() != 0 || !req_ready || slave_busy) && w < 3000) begin
            @(negedge CLOCK_50);
            w++;
        end
        if (w >= 3000) check("idle_wait_expired", 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int p0;
    int w;
    int c_rsp;
    bit ready_ok;
    initial begin
        #5;
        check("rst_req_ready", {31'h0, req_ready}, 1);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 0);
        check("rst_start_n", {31'h0, spi_start_n}, 1);
        check("rst_data_in", {24'h0, spi_data_in}, 0);
        check("rst_rsp_data", {24'h0, rsp_data}, 0);
        check("rst_rsp_err", {31'h0, rsp_err}, 0);
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b1;

        // Directed write and read.
        p0 = start_pulses;
        issue(1'b0, 6'h12, 8'h00, 8'h00, 1'b0);
        wait_idle();
        check("write_pulses", start_pulses - p0, 2);
        issue(1'b1, 6'h14, 8'h00, 8'h80, 1'b0);
        wait_idle();

        // Timeout with no busy: only the address byte is started.
        slave_en = 1'b0;
        p0 = start_pulses;
        issue(1'b1, 6'h05, 8'h00, 8'h00, 1'b1);
        wait_idle();
        check("tmo_pulses", start_pulses - p0, 1);
        check("tmo_delay_window",
              {31'h0, ((last_rsp_cyc - t_start) >= 98 && (last_rsp_cyc - t_start) <= 106)}, 1);
        slave_en = 1'b1;

        // Reset during the data byte.
        p0 = rsp_count;
        issue(1'b0, 6'h3F, 8'h5C, 8'h00, 1'b0);
        w = 0;
        while (!(exp_byte.size() == 0 && slave_busy) && w < 200) begin
            @(negedge CLOCK_50);
            w++;
        end
        check("reached_data_xfer", {31'h0, slave_busy}, 1);
        #3 reset = 1'b0;
        #1;
        exp_rsp.delete();
        check("abort_req_ready", {31'h0, req_ready}, 1);
        check("abort_rsp_valid", {31'h0, rsp_valid}, 0);
        check("abort_start_n", {31'h0, spi_start_n}, 1);
        check("abort_data_in", {24'h0, spi_data_in}, 0);
        check("abort_rsp_data", {24'h0, rsp_data}, 0);
        check("abort_rsp_err", {31'h0, rsp_err}, 0);
        last_rsp_data = 8'h00;
        w = 0;
        while (slave_busy && w < 50) begin
            @(negedge CLOCK_50);
            w++;
        end
        @(negedge CLOCK_50);
        reset = 1'b1;
        check("abort_no_rsp", rsp_count - p0, 0);
        issue(1'b0, 6'h2A, 8'h80, 8'h00, 1'b0);
        wait_idle();

        // Back-to-back with req_valid held; fields change mid-transfer and must be ignored.
        wait_ready();
        push_expect(1'b0, 6'h2B, 8'hA9, 8'h00, 1'b0);
        push_expect(1'b0, 6'h2C, 8'h03, 8'h00, 1'b0);
        req_valid = 1'b1;
        req_rw = 1'b0; req_addr = 6'h2B; req_wdata = 8'hA9;
        @(negedge CLOCK_50);
        req_addr = 6'h2C; req_wdata = 8'h03;
        ready_ok = 1'b1;
        w = 0;
        while (!rsp_valid && w < 200) begin
            if (req_ready) ready_ok = 1'b0;
            @(negedge CLOCK_50);
            w++;
        end
        if (req_ready) ready_ok = 1'b0;
        check("b2b_ready_low", {31'h0, ready_ok}, 1);
        c_rsp = cyc;
        w = 0;
        @(negedge CLOCK_50);
        while (spi_start_n && w < 10) begin
            @(negedge CLOCK_50);
            w++;
        end
        check("b2b_accept_cycle", cyc, c_rsp + 2);
        req_valid = 1'b0;
        wait_idle();

        // Stray busy while idle.
        p0 = rsp_count;
        w = start_pulses;
        stray_busy = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        stray_busy = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check("stray_ready", {31'h0, req_ready}, 1);
        check("stray_no_rsp", rsp_count - p0, 0);
        check("stray_no_start", start_pulses - w, 0);
        check("rsp_data_hold", {24'h0, rsp_data}, {24'h0, last_rsp_data});

        // Random traffic.
        for (int i = 0; i < 20; i++) begin
            issue(1'($urandom), 6'($urandom), 8'($urandom), 8'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();
        check("bytes_drained", exp_byte.size(), 0);
        check("rsps_drained", exp_rsp.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rc522_reg_access.md
RC522_REG_ACCESS -- requirements
Module: rc522_reg_access

Interface
REQ-001 SHALL have parameter XFER_TIMEOUT, default 28'd50_000_000, meaning the maximum CLOCK_50 cycles from a start pulse until the transfer ends (busy falls).
REQ-002 SHALL have parameter DUMMY_BYTE, default 8'h00, meaning the second byte sent on a register read.
REQ-003 SHALL use one clock, CLOCK_50; reset is asynchronous and active-low, port reset.
REQ-004 SHALL have ports (name  direction  width  meaning):
  CLOCK_50  in  1  system clock, 50 MHz
  reset  in  1  asynchronous active-low reset
  req_valid  in  1  register access request
  req_ready  out  1  block idle, can accept a request
  req_rw  in  1  1 = read, 0 = write
  req_addr  in  6  RC522 register address
  req_wdata  in  8  write data
  rsp_valid  out  1  one-cycle completion pulse
  rsp_data  out  8  read data (8'h00 after a write or error)
  rsp_err  out  1  timeout flag, valid with rsp_valid
  spi_start_n  out  1  active-low start to the spi_master, 8-bit instance
  spi_data_in  out  8  byte to transmit
  spi_busy  in  1  spi_master busy_transaction
  spi_data_out  in  8  byte received by the spi_master

Function
REQ-005 SHALL implement these states: IDLE, ADDR_START, ADDR_WAIT, ADDR_XFER, DATA_START, DATA_WAIT, DATA_XFER, DONE.
REQ-006 SHALL drive req_ready high only in IDLE. A request is accepted when req_valid and req_ready are both high on a rising edge.
REQ-007 On acceptance, SHALL latch req_rw, req_addr and req_wdata, and go to ADDR_START.
REQ-008 SHALL form the address byte as {req_rw, req_addr, 1'b0}: read gives bit7 = 1; write gives bit7 = 0; bit0 is always 0.
REQ-009 In ADDR_START and DATA_START, SHALL drive spi_start_n low for exactly one cycle, then go to the matching WAIT state.
REQ-010 SHALL hold spi_data_in stable from the START cycle until spi_busy falls in the matching XFER state.
REQ-011 In a WAIT state, SHALL move to XFER when spi_busy = 1.
REQ-012 In an XFER state, SHALL move on when spi_busy = 0: from ADDR_XFER to DATA_START, from DATA_XFER to DONE.
REQ-013 The second byte SHALL be the latched wdata for a write, or DUMMY_BYTE for a read.
REQ-014 On the DATA_XFER exit edge, SHALL capture spi_data_out into rsp_data for a read; for a write, rsp_data SHALL be 8'h00.
REQ-015 The address-byte spi_data_out SHALL be discarded.
REQ-016 In DONE, SHALL assert rsp_valid for one cycle, with rsp_err = 0, then return to IDLE.
REQ-017 SHALL keep a 28-bit counter that clears in each START state and increments in the WAIT and XFER states.
REQ-018 If the counter reaches XFER_TIMEOUT in any WAIT or XFER state, SHALL go to DONE with rsp_err = 1 and rsp_data = 8'h00, and SHALL NOT send the second byte.
REQ-019 Latency: with acceptance at edge T, spi_start_n SHALL be low during cycle T+1 (the ADDR_START cycle).
REQ-020 For an ideal slave, rsp_valid SHALL follow the second busy fall by exactly 1 cycle.
REQ-021 Back-to-back: the next request SHALL be accepted no earlier than the IDLE cycle after DONE; req_valid held during DONE is accepted on the following edge.
REQ-022 SHALL ignore req_* inputs outside IDLE.
REQ-023 SHALL ignore spi_busy in IDLE and DONE.
REQ-024 A spi_busy that is already high in a START state SHALL NOT skip the WAIT state; WAIT exits on the next sampled spi_busy = 1.
REQ-025 rsp_data SHALL hold its value until the next rsp_valid.

Reset
REQ-026 While reset = 0, SHALL asynchronously force: state IDLE, req_ready = 1, rsp_valid = 0, rsp_err = 0, rsp_data = 8'h00, spi_start_n = 1, spi_data_in = 8'h00, counter = 0.
REQ-027 Reset asserted mid-transfer SHALL abort the transfer with no rsp_valid.
REQ-028 After reset is released, SHALL accept a new request on the first edge that sees req_valid high.

Verification
REQ-029 Write: addr 6'h12, wdata 8'h00; slave busy 5 cycles per byte.
  -> spi_data_in 8'h24, then 8'h00.
  -> two one-cycle spi_start_n pulses.
  -> rsp_valid with rsp_data 8'h00, rsp_err 0.
REQ-030 Read: addr 6'h14; slave returns 8'h80 on the second byte.
  -> spi_data_in 8'hA8, then 8'h00.
  -> rsp_data 8'h80, rsp_err 0.
REQ-031 Timeout: XFER_TIMEOUT = 100, spi_busy held 0.
  -> rsp_valid with rsp_err 1 about 101 cycles after the first start pulse.
  -> only one spi_start_n pulse issued.
REQ-032 Reset mid-operation: pull reset low during DATA_XFER.
  -> outputs at reset values immediately (asynchronous); no rsp_valid.
  -> a fresh write to 6'h2A, wdata 8'h80, completes normally with bytes 8'h54, 8'h80.
REQ-033 Back-to-back: req_valid held high for two writes (6'h2B/8'hA9, then 6'h2C/8'h03).
  -> req_ready is low from acceptance through DONE.
  -> second request accepted on the cycle after rsp_valid.
  -> byte order 8'h56, 8'hA9, 8'h58, 8'h03.
REQ-034 Stray busy: spi_busy pulse while IDLE.
  -> no state change, no rsp_valid.
